// File: rtl/pipe_adder_n.sv
// rtl/pipe_adder_n.sv - elastic multi-operand adder pipeline with Rin/Ain and Rout/Aout handshakes
module pipe_adder_n #(
    parameter  int WIDTH  = 8,
    parameter  int NUM    = 3,
    parameter  bit SIGNED = 1'b0,
    localparam int OUT_W  = WIDTH + $clog2(NUM),
    localparam int OCC_W  = $clog2(NUM) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM*WIDTH-1:0]   a_bus,
    input  logic [NUM-1:0]         sub,
    input  logic                   Rin,
    output logic                   Ain,
    output logic [OUT_W-1:0]       out,
    output logic                   Rout,
    input  logic                   Aout,
    output logic [OCC_W-1:0]       occ
);

    localparam int L = NUM - 1;

    // Widen an operand to the result width and negate it when it is subtracted.
    function automatic logic [OUT_W-1:0] ext_op(input logic [WIDTH-1:0] v, input logic neg);
        logic [OUT_W-1:0] x;
        x = {{(OUT_W-WIDTH){SIGNED & v[WIDTH-1]}}, v};
        return neg ? (~x + OUT_W'(1)) : x;
    endfunction

    logic [L:1]       w_valid;
    logic [L:1]       w_load;
    logic [OUT_W-1:0] w_sum [1:L];

    // Ready chain: a stage may load when empty or when the stage after it is moving.
    always_comb begin
        w_load    = '0;
        w_load[L] = !w_valid[L] || Aout;
        for (int s = L - 1; s >= 1; s--) begin
            w_load[s] = !w_valid[s] || w_load[s+1];
        end
    end

    for (genvar s = 1; s <= L; s++) begin : g_stg
        // Operands still waiting to be added once this stage holds a partial sum.
        localparam int K = NUM - 1 - s;

        logic             r_valid;
        logic [OUT_W-1:0] r_sum;
        logic             w_in_valid;
        logic [OUT_W-1:0] w_in_sum;

        if (s == 1) begin : g_head
            assign w_in_valid = Rin;
            assign w_in_sum   = ext_op(a_bus[0 +: WIDTH], sub[0])
                              + ext_op(a_bus[WIDTH +: WIDTH], sub[1]);
        end else begin : g_body
            assign w_in_valid = w_valid[s-1];
            assign w_in_sum   = w_sum[s-1]
                              + ext_op(g_stg[s-1].g_skew.r_ops[0 +: WIDTH],
                                       g_stg[s-1].g_skew.r_subs[0]);
        end

        // Partial sum and valid bit; data only moves when a real transaction arrives.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_sum   <= '0;
            end else if (w_load[s]) begin
                r_valid <= w_in_valid;
                if (w_in_valid) begin
                    r_sum <= w_in_sum;
                end
            end
        end

        assign w_valid[s] = r_valid;
        assign w_sum[s]   = r_sum;

        if (K > 0) begin : g_skew
            logic [K*WIDTH-1:0] r_ops;
            logic [K-1:0]       r_subs;
            logic [K*WIDTH-1:0] w_in_ops;
            logic [K-1:0]       w_in_subs;

            if (s == 1) begin : g_src
                assign w_in_ops  = a_bus[NUM*WIDTH-1 : 2*WIDTH];
                assign w_in_subs = sub[NUM-1:2];
            end else begin : g_src
                assign w_in_ops  = g_stg[s-1].g_skew.r_ops[(K+1)*WIDTH-1 : WIDTH];
                assign w_in_subs = g_stg[s-1].g_skew.r_subs[K:1];
            end

            // Skew registers carry the not-yet-added operands alongside the partial sum.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ops  <= '0;
                    r_subs <= '0;
                end else if (w_load[s] && w_in_valid) begin
                    r_ops  <= w_in_ops;
                    r_subs <= w_in_subs;
                end
            end
        end
    end

    // Occupancy is the number of stages currently holding a transaction.
    always_comb begin
        occ = '0;
        for (int s = 1; s <= L; s++) begin
            occ = occ + OCC_W'(w_valid[s]);
        end
    end

    assign out  = w_sum[L];
    assign Rout = w_valid[L];
    assign Ain  = w_load[1] && !rst;

endmodule

// File: tb/tb_pipe_adder_n.sv
// tb/tb_pipe_adder_n.sv - self-checking bench for pipe_adder_n
module tb_pipe_adder_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Group A: WIDTH=8, NUM=3, unsigned and signed instances share inputs.
    logic        rst_a, rin_a, aout_a;
    logic [23:0] bus_a;
    logic [2:0]  sub_a;
    logic        ain_u, rout_u, ain_s, rout_s;
    logic [9:0]  out_u, out_s;
    logic [2:0]  occ_u, occ_s;

    // Group B: WIDTH=4, NUM=5, unsigned.
    logic        rst_b, rin_b, aout_b;
    logic [19:0] bus_b;
    logic [4:0]  sub_b;
    logic        ain_b, rout_b;
    logic [6:0]  out_b;
    logic [3:0]  occ_b;

    pipe_adder_n #(.WIDTH(8), .NUM(3), .SIGNED(1'b0)) u_u (
        .clk(clk), .rst(rst_a), .a_bus(bus_a), .sub(sub_a), .Rin(rin_a), .Ain(ain_u),
        .out(out_u), .Rout(rout_u), .Aout(aout_a), .occ(occ_u));

    pipe_adder_n #(.WIDTH(8), .NUM(3), .SIGNED(1'b1)) u_s (
        .clk(clk), .rst(rst_a), .a_bus(bus_a), .sub(sub_a), .Rin(rin_a), .Ain(ain_s),
        .out(out_s), .Rout(rout_s), .Aout(aout_a), .occ(occ_s));

    pipe_adder_n #(.WIDTH(4), .NUM(5), .SIGNED(1'b0)) u_b (
        .clk(clk), .rst(rst_b), .a_bus(bus_b), .sub(sub_b), .Rin(rin_b), .Ain(ain_b),
        .out(out_b), .Rout(rout_b), .Aout(aout_b), .occ(occ_b));

    int n_tests = 0;
    int n_fail  = 0;
    int q_u[$], q_s[$], q_b[$];
    int got_u[$], got_b[$];
    int last_u, last_s;
    bit acc_a, acc_b;
    int sent;

    // Reference: interpret each operand, add or subtract it, wrap to the result width.
    function automatic int expv(input logic [63:0] bus, input logic [7:0] sb, input int n,
                                input int w, input bit sgn, input int ow);
        int s;
        int v;
        s = 0;
        for (int i = 0; i < n; i++) begin
            v = int'((bus >> (i*w)) & ((64'd1 << w) - 64'd1));
            if (sgn && v >= (1 << (w-1))) v = v - (1 << w);
            s = sb[i] ? s - v : s + v;
        end
        return s & ((1 << ow) - 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_a();
        #1;
        acc_a = rin_a && ain_u;
        if (acc_a) begin
            q_u.push_back(expv(64'(bus_a), 8'(sub_a), 3, 8, 1'b0, 10));
            q_s.push_back(expv(64'(bus_a), 8'(sub_a), 3, 8, 1'b1, 10));
        end
        if (rout_u && aout_a) begin
            if (q_u.size() == 0) check("stale_u", 32'(rout_u), 32'd0);
            else begin
                last_u = int'(out_u);
                got_u.push_back(last_u);
                check("out_u", 32'(out_u), 32'(q_u.pop_front()));
            end
        end
        if (rout_s && aout_a) begin
            if (q_s.size() == 0) check("stale_s", 32'(rout_s), 32'd0);
            else begin
                last_s = int'(out_s);
                check("out_s", 32'(out_s), 32'(q_s.pop_front()));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_b();
        #1;
        acc_b = rin_b && ain_b;
        if (acc_b) q_b.push_back(expv(64'(bus_b), 8'(sub_b), 5, 4, 1'b0, 7));
        if (rout_b && aout_b) begin
            if (q_b.size() == 0) check("stale_b", 32'(rout_b), 32'd0);
            else begin
                got_b.push_back(int'(out_b));
                check("out_b", 32'(out_b), 32'(q_b.pop_front()));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [2:0] sb);
        bus_a = {c, b, a};
        sub_a = sb;
        rin_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc_a();
            if (acc_a) break;
        end
        check("send_acc", 32'(acc_a), 32'd1);
        rin_a = 1'b0;
    endtask

    task automatic drain_a();
        aout_a = 1'b1;
        for (int i = 0; i < 20 && (q_u.size() != 0 || q_s.size() != 0); i++) cyc_a();
        check("drain_a", 32'(q_u.size() + q_s.size()), 32'd0);
    endtask

    initial begin
        rst_a = 1'b1; rin_a = 1'b0; aout_a = 1'b1; bus_a = '0; sub_a = '0;
        rst_b = 1'b1; rin_b = 1'b0; aout_b = 1'b1; bus_b = '0; sub_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 32'(out_u), 32'd0);
        check("rst_rout", 32'(rout_u), 32'd0);
        check("rst_occ", 32'(occ_u), 32'd0);
        check("rst_ain", 32'(ain_u), 32'd0);
        check("rst_occ_b", 32'(occ_b), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        check("ain_after_rst", 32'(ain_u), 32'd1);

        // Single transaction latency: result one cycle after acceptance.
        bus_a = {8'd50, 8'd100, 8'd200}; sub_a = 3'b000; rin_a = 1'b1;
        cyc_a();
        check("lat_acc", 32'(acc_a), 32'd1);
        rin_a = 1'b0;
        check("lat_early", 32'(rout_u), 32'd0);
        cyc_a();
        check("lat_rout", 32'(rout_u), 32'd1);
        check("lat_out", 32'(out_u), 32'h15E);
        cyc_a();
        check("lat_gone", 32'(rout_u), 32'd0);

        // Subtraction.
        send_a(8'd10, 8'd5, 8'd20, 3'b100);
        drain_a();
        check("sub_neg5", 32'(last_u), 32'h3FB);
        send_a(8'd1, 8'd2, 8'd3, 3'b011);
        drain_a();
        check("sub_zero", 32'(last_u), 32'h000);

        // Signed extension.
        send_a(8'h80, 8'h80, 8'h80, 3'b000);
        drain_a();
        check("sgn_min", 32'(last_s), 32'h280);
        check("uns_80", 32'(last_u), 32'h180);
        send_a(8'h7F, 8'h7F, 8'h01, 3'b000);
        drain_a();
        check("sgn_max", 32'(last_s), 32'h0FF);

        // Back-pressure and full-pipe accept-while-drain.
        got_u.delete();
        aout_a = 1'b0;
        bus_a = {8'd3, 8'd2, 8'd1}; rin_a = 1'b1;
        cyc_a();
        check("bp_acc1", 32'(acc_a), 32'd1);
        bus_a = {8'd6, 8'd5, 8'd4};
        cyc_a();
        check("bp_acc2", 32'(acc_a), 32'd1);
        bus_a = {8'd9, 8'd8, 8'd7};
        #1;
        check("bp_ain", 32'(ain_u), 32'd0);
        check("bp_occ", 32'(occ_u), 32'd2);
        cyc_a();
        check("bp_hold", 32'(acc_a), 32'd0);
        aout_a = 1'b1;
        cyc_a();
        check("bp_swap_acc", 32'(acc_a), 32'd1);
        rin_a = 1'b0;
        check("bp_swap_occ", 32'(occ_u), 32'd2);
        cyc_a();
        cyc_a();
        check("bp_count", 32'(got_u.size()), 32'd3);
        if (got_u.size() == 3) begin
            check("bp_r0", 32'(got_u[0]), 32'd6);
            check("bp_r1", 32'(got_u[1]), 32'd15);
            check("bp_r2", 32'(got_u[2]), 32'd24);
        end

        // Reset with two transactions in flight.
        aout_a = 1'b0;
        send_a(8'd1, 8'd1, 8'd1, 3'b000);
        send_a(8'd2, 8'd2, 8'd2, 3'b000);
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_rout", 32'(rout_u), 32'd0);
        check("mid_rst_occ", 32'(occ_u), 32'd0);
        check("mid_rst_out", 32'(out_u), 32'd0);
        q_u.delete(); q_s.delete();
        rst_a = 1'b0; aout_a = 1'b1;
        repeat (4) cyc_a();
        check("no_stale", 32'(rout_u), 32'd0);
        send_a(8'd4, 8'd5, 8'd6, 3'b000);
        drain_a();
        check("post_rst", 32'(last_u), 32'd15);

        // Random stream on group A with random back-pressure and sub bits.
        got_u.delete();
        sent = 0;
        rin_a = 1'b1; bus_a = 24'($urandom); sub_a = 3'($urandom);
        for (int c = 0; c < 400 && !(sent == 20 && q_u.size() == 0 && q_s.size() == 0); c++) begin
            aout_a = 1'($urandom_range(0, 1));
            cyc_a();
            if (acc_a) begin
                sent++;
                if (sent < 20) begin
                    bus_a = 24'($urandom); sub_a = 3'($urandom);
                end else rin_a = 1'b0;
            end
        end
        check("rand_a_count", 32'(got_u.size()), 32'd20);

        // Streaming on the 5-operand, 4-bit instance.
        got_b.delete();
        sent = 0;
        rin_b = 1'b1; bus_b = 20'($urandom); sub_b = 5'($urandom);
        for (int c = 0; c < 400 && !(sent == 16 && q_b.size() == 0); c++) begin
            aout_b = 1'($urandom_range(0, 1));
            cyc_b();
            if (acc_b) begin
                sent++;
                if (sent < 16) begin
                    bus_b = 20'($urandom); sub_b = 5'($urandom);
                end else rin_b = 1'b0;
            end
        end
        check("stream_b_count", 32'(got_b.size()), 32'd16);
        check("stream_b_occ", 32'(occ_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
